// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_8n1
// Description : 8N1 UART receiver with mid-bit sampling, one-entry receive
//               buffer on a valid/ready handshake, sticky frame/overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_8n1 #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_data      = 3'd2;
    localparam logic [2:0] c_st_stop      = 3'd3;
    localparam logic [2:0] c_st_wait_idle = 3'd4;

    logic             r_sync1, r_sync2;
    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit_idx, w_bit_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_rx_data, w_rx_data_nxt;
    logic             r_rx_valid, w_rx_valid_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             r_overrun, w_overrun_nxt;
    logic             w_rx_s;
    logic             w_consume;

    assign w_rx_s    = r_sync2;
    assign w_consume = r_rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= rxd;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = r_rx_valid;
        w_frame_err_nxt = r_frame_err;
        w_overrun_nxt   = r_overrun;

        // Clear first so that a flag set on the same edge takes priority.
        if (err_clr) begin
            w_frame_err_nxt = 1'b0;
            w_overrun_nxt   = 1'b0;
        end
        if (w_consume) begin
            w_rx_valid_nxt = 1'b0;
        end

        case (r_state)
            c_st_idle: begin
                if (!w_rx_s) begin
                    w_state_nxt = c_st_start;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_start: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_rx_s ? c_st_idle : c_st_data;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            c_st_data: begin
                if (r_cnt == c_bit_last) begin
                    w_shift_nxt   = {w_rx_s, r_shift[7:1]};
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = c_st_stop;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            c_st_stop: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        // A consume on this edge frees the buffer for the new byte.
                        if (!r_rx_valid || w_consume) begin
                            w_rx_data_nxt  = r_shift;
                            w_rx_valid_nxt = 1'b1;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = c_st_wait_idle;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            c_st_wait_idle: begin
                if (w_rx_s) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign busy      = (r_state != c_st_idle);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_8n1
// Description : Directed self-checking bench for uart_rx_8n1 at default rates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_8n1;

    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;

    uart_rx_8n1 dut (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #20 clk = ~clk;

    // Drives one frame starting on the next falling clock edge; rxd is left at
    // the stop level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic consume();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'hA5, 1'b1);
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL a5_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL a5_data: got %h expected a5", rx_data); end
        checks++; if ({frame_err, overrun} !== 2'b00) begin failures++; $display("FAIL a5_flags: got %b expected 00", {frame_err, overrun}); end
        consume();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL a5_consume: got %b expected 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        logic [7:0] got_b[3];
        int  n_pulses = 0;
        int  long_pulse = 0;
        logic prev_v = 1'b0;
        logic done = 1'b0;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        got_b[0] = 8'hxx; got_b[1] = 8'hxx; got_b[2] = 8'hxx;
        rx_ready = 1'b1;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h3C, 1'b1);
                repeat (20) @(negedge clk);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (rx_valid === 1'b1) begin
                        if (prev_v) long_pulse++;
                        else begin
                            if (n_pulses < 3) got_b[n_pulses] = rx_data;
                            n_pulses++;
                        end
                    end
                    prev_v = (rx_valid === 1'b1);
                end
            end
        join
        rx_ready = 1'b0;
        checks++; if (n_pulses !== 3) begin failures++; $display("FAIL b2b_pulse_count: got %0d expected 3", n_pulses); end
        checks++; if (long_pulse !== 0) begin failures++; $display("FAIL b2b_pulse_width: got %0d extra cycles expected 0", long_pulse); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got_b[i] !== exp_b[i]) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_b[i], exp_b[i]); end
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ovr_data: got %h expected 11", rx_data); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ovr_data_after_clr: got %h expected 11", rx_data); end
        consume();
    endtask

    task automatic test_framing();
        send_frame(8'h55, 1'b0);
        repeat (20 * CPB) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_flag: got %b expected 1", frame_err); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ferr_valid: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_idle_busy: got %b expected 1", busy); end
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_release_busy: got %b expected 0", busy); end
        send_frame(8'h66, 1'b1);
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ferr_next_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h66) begin failures++; $display("FAIL ferr_next_data: got %h expected 66", rx_data); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_sticky: got %b expected 1", frame_err); end
        consume();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
    endtask

    task automatic test_glitch_and_reset();
        logic [7:0] b = 8'h81;
        @(negedge clk); rxd = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_during: got %b expected 1", busy); end
        repeat (40) @(negedge clk); rxd = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_after: got %b expected 0", busy); end
        checks++; if ({rx_valid, frame_err, overrun} !== 3'b000) begin failures++; $display("FAIL glitch_outputs: got %b expected 000", {rx_valid, frame_err, overrun}); end
        // Partial 0x81 frame, reset lands in the middle of bit 4.
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = b[4];
        repeat (CPB / 2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if ({rx_valid, frame_err, overrun} !== 3'b000) begin failures++; $display("FAIL midreset_outputs: got %b expected 000", {rx_valid, frame_err, overrun}); end
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h81, 1'b1);
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL midreset_next_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL midreset_next_data: got %h expected 81", rx_data); end
        consume();
    endtask

    task automatic test_collision();
        rx_ready = 1'b0;
        send_frame(8'h10, 1'b1);
        checks++; if ({rx_valid, rx_data} !== 9'h110) begin failures++; $display("FAIL coll_setup: got %b/%h expected 1/10", rx_valid, rx_data); end
        fork
            send_frame(8'h20, 1'b1);
            begin
                // Stop sample lands on the 2064th rising edge after the start
                // edge is driven: 2 sync + 1 detect + 108 half bit + 9*217.
                wait (rxd == 1'b0);
                repeat (2063) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL coll_valid: got %b expected 1", rx_valid); end
                checks++; if (rx_data !== 8'h20) begin failures++; $display("FAIL coll_data: got %h expected 20", rx_data); end
                checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL coll_overrun: got %b expected 0", overrun); end
            end
        join
        consume();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL coll_drain: got %b expected 0", rx_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch_and_reset();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
